xlr8_pcint_arb: RTL and testbench

XLR8_PCINT_ARB -- requirements
Module: xlr8_pcint_arb

---
 rtl/xlr8_pcint_arb.sv | 145 ++++++++++++++
 tb/tb_xlr8_pcint_arb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xlr8_pcint_arb.sv
// xlr8_pcint_arb: arbitrates pin-change interrupt groups onto the single AVR core request.
// The ARBSR status register is readable on the I/O bus.
// Build option: define XLR8_PCINT_ARB_RR_EN for round-robin arbitration. With it undefined,
// arbitration is fixed priority, where the lowest index wins.
module xlr8_pcint_arb #(
    parameter int unsigned NUM_SRC       = 4,
    parameter int unsigned VEC_BASE      = 0,
    parameter int unsigned TIMEOUT       = 64,
    parameter int unsigned ARBSR_Address = 0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [5:0]         adr,
    input  logic               iore,
    output logic [7:0]         dbus_out,
    output logic               out_en,
    input  logic [NUM_SRC-1:0] src_irq,
    output logic [NUM_SRC-1:0] src_ack,
    output logic               core_irq,
    output logic [4:0]         core_vec,
    input  logic               core_ack
);

    localparam logic [5:0] ArbsrAdr = 6'(ARBSR_Address);

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    state_e             state_q, state_d;
    logic [2:0]         gidx_q, gidx_d;
    logic [7:0]         timer_q, timer_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         last_q, last_d;
    logic               to_q, to_d;
    logic [NUM_SRC-1:0] ack_q, ack_d;

    logic [7:0] req8;
    logic [3:0] cand;
    logic       win_found;
    logic [2:0] win_idx;
    logic       timeout_hit;

    // Zero-padded request vector so any 3-bit index is in range.
    assign req8 = 8'(src_irq);

    // Winner: first requester at or after the pointer, wrapping at NUM_SRC.
    // In the fixed-priority build the pointer stays 0, so this is the lowest requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 4'd0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cand = 4'(ptr_q) + 4'(i);
            if (cand >= 4'(NUM_SRC)) begin
                cand = cand - 4'(NUM_SRC);
            end
            if (!win_found && req8[cand[2:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[2:0];
            end
        end
    end

    // This grant cycle is the TIMEOUT-th one.
    assign timeout_hit = ({1'b0, timer_q} + 9'd1) >= 9'(TIMEOUT);

    // Next state: grant, ack, withdrawal, timeout and status flags.
    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        to_d    = to_q;
        ack_d   = '0;
        // A read clears TO; a timeout set on the same edge overrides it below.
        if (out_en) begin
            to_d = 1'b0;
        end
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    gidx_d  = win_idx;
                    timer_d = 8'd0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (timer_q != 8'hFF) begin
                    timer_d = timer_q + 8'd1;
                end
                if (core_ack) begin
                    for (int unsigned i = 0; i < NUM_SRC; i++) begin
                        ack_d[i] = (gidx_q == 3'(i));
                    end
                    last_d  = gidx_q;
                    state_d = StGap;
`ifdef XLR8_PCINT_ARB_RR_EN
                    ptr_d = (gidx_q == 3'(NUM_SRC - 1)) ? 3'd0 : gidx_q + 3'd1;
`else
                    ptr_d = 3'd0;
`endif
                end else if (!req8[gidx_q]) begin
                    state_d = StIdle;
                end else if (timeout_hit) begin
                    to_d    = 1'b1;
                    state_d = StIdle;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            gidx_q  <= 3'd0;
            timer_q <= 8'd0;
            ptr_q   <= 3'd0;
            last_q  <= 3'd0;
            to_q    <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            timer_q <= timer_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            to_q    <= to_d;
            ack_q   <= ack_d;
        end
    end

    assign core_irq = (state_q == StGrant);
    assign core_vec = core_irq ? (5'(VEC_BASE) + {2'b00, gidx_q}) : 5'd0;
    assign src_ack  = ack_q;
    assign out_en   = iore && (adr == ArbsrAdr);
    assign dbus_out = out_en ? {to_q, state_q != StIdle, 3'b000, last_q} : 8'h00;

endmodule

// File: tb/tb_xlr8_pcint_arb.sv
// tb_xlr8_pcint_arb: directed and randomized checks of xlr8_pcint_arb against a
// transaction-level model (winner by distance from the pointer, ARBSR contents).
module tb_xlr8_pcint_arb;

    localparam int unsigned N      = 4;
    localparam int unsigned VB     = 30;
    localparam int unsigned TO_CYC = 4;
    localparam logic [5:0]  ADDR   = 6'h2A;

    logic         clk;
    logic         rstn;
    logic [5:0]   adr;
    logic         iore;
    logic [7:0]   dbus_out;
    logic         out_en;
    logic [N-1:0] src_irq;
    logic [N-1:0] src_ack;
    logic         core_irq;
    logic [4:0]   core_vec;
    logic         core_ack;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int         ptr_m  = 0;
    logic [2:0] last_m = 3'd0;
    logic       to_m   = 1'b0;

    xlr8_pcint_arb #(
        .NUM_SRC      (N),
        .VEC_BASE     (VB),
        .TIMEOUT      (TO_CYC),
        .ARBSR_Address(32'(ADDR))
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .adr     (adr),
        .iore    (iore),
        .dbus_out(dbus_out),
        .out_en  (out_en),
        .src_irq (src_irq),
        .src_ack (src_ack),
        .core_irq(core_irq),
        .core_vec(core_vec),
        .core_ack(core_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner = requester with the smallest forward distance from the pointer.
    function automatic int model_winner(input logic [N-1:0] req);
        int best  = -1;
        int bestd = 1000;
        for (int i = 0; i < int'(N); i++) begin
            if (req[i]) begin
`ifdef XLR8_PCINT_ARB_RR_EN
                int d = (i - ptr_m + int'(N)) % int'(N);
`else
                int d = i;
`endif
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [7:0] arbsr_exp(input logic busy);
        return {to_m, busy, 3'b000, last_m};
    endfunction

    task automatic read_arbsr(input string tag, input logic busy);
        iore = 1'b1;
        adr  = ADDR;
        #1;
        chk({tag, "_en"}, 32'(out_en), 32'd1);
        chk(tag, 32'(dbus_out), 32'(arbsr_exp(busy)));
        step();
        iore = 1'b0;
        adr  = 6'd0;
        to_m = 1'b0;
    endtask

    // Starts in an IDLE cycle; ends in the IDLE cycle after GAP.
    task automatic do_grant(input logic [N-1:0] req, input int dly, input bit drop,
                            output int w, output logic [4:0] vec_obs);
        src_irq = req;
        w       = model_winner(req);
        step();
        vec_obs = core_vec;
        chk("irq_rise", 32'(core_irq), 32'd1);
        chk("vec", 32'(core_vec), 32'((VB + w) % 32));
        chk("ack_quiet", 32'(src_ack), 32'd0);
        for (int k = 0; k < dly; k++) begin
            step();
            chk("irq_hold", 32'(core_irq), 32'd1);
        end
        core_ack = 1'b1;
        if (drop) src_irq[w] = 1'b0;
        step();
        core_ack = 1'b0;
        chk("ack_pulse", 32'(src_ack), 32'(1) << w);
        chk("gap_irq", 32'(core_irq), 32'd0);
        last_m = 3'(w);
`ifdef XLR8_PCINT_ARB_RR_EN
        ptr_m = (w + 1) % int'(N);
`else
        ptr_m = 0;
`endif
        step();
        chk("ack_once", 32'(src_ack), 32'd0);
        chk("idle_irq", 32'(core_irq), 32'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        ptr_m  = 0;
        last_m = 3'd0;
        to_m   = 1'b0;
        rstn   = 1'b1;
    endtask

    initial begin
        int         w;
        logic [4:0] v;
        int         exp_order[5];
        rstn     = 1'b0;
        adr      = 6'd0;
        iore     = 1'b0;
        src_irq  = '0;
        core_ack = 1'b0;

        // Reset state.
        do_reset();
        chk("rst_irq", 32'(core_irq), 32'd0);
        chk("rst_vec", 32'(core_vec), 32'd0);
        chk("rst_ack", 32'(src_ack), 32'd0);
        chk("rst_en", 32'(out_en), 32'd0);
        chk("rst_dbus", 32'(dbus_out), 32'd0);
        read_arbsr("rst_arbsr", 1'b0);

        // Wrong address does not decode.
        iore = 1'b1;
        adr  = ADDR + 6'd1;
        #1;
        chk("bad_adr_en", 32'(out_en), 32'd0);
        chk("bad_adr_dbus", 32'(dbus_out), 32'd0);
        iore = 1'b0;
        adr  = 6'd0;

        // Single source, ack three cycles after core_irq rises.
        do_grant(4'b0001, 3, 1'b1, w, v);
        read_arbsr("single_arbsr", 1'b0);

        // Grant order with all sources held.
        do_reset();
`ifdef XLR8_PCINT_ARB_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 5; i++) begin
            do_grant(4'b1111, 0, 1'b0, w, v);
            chk("order", 32'(v), 32'((VB + exp_order[i]) % 32));
        end
        src_irq = '0;
        step();

        // core_ack outside GRANT is ignored.
        core_ack = 1'b1;
        step();
        core_ack = 1'b0;
        chk("stray_ack", 32'(src_ack), 32'd0);
        chk("stray_irq", 32'(core_irq), 32'd0);
        step();
        chk("stray_ack2", 32'(src_ack), 32'd0);

        // Withdrawal on source 2 (vector wraps modulo 32).
        src_irq = 4'b0100;
        step();
        chk("wd_vec", 32'(core_vec), 32'((VB + 2) % 32));
        step();
        chk("wd_hold", 32'(core_irq), 32'd1);
        src_irq = '0;
        step();
        chk("wd_irq", 32'(core_irq), 32'd0);
        chk("wd_ack", 32'(src_ack), 32'd0);
        step();
        chk("wd_ack2", 32'(src_ack), 32'd0);
        read_arbsr("wd_arbsr", 1'b0);
        do_grant(4'b1111, 1, 1'b0, w, v);
        src_irq = '0;
        step();

        // Ack and withdrawal on the same cycle still acknowledges.
        do_grant(4'b0100, 1, 1'b1, w, v);

        // Timeout with no ack.
        src_irq = 4'b0010;
        step();
        for (int k = 0; k < int'(TO_CYC) - 1; k++) begin
            chk("to_hold", 32'(core_irq), 32'd1);
            step();
        end
        chk("to_last_cycle", 32'(core_irq), 32'd1);
        step();
        src_irq = '0;
        to_m    = 1'b1;
        chk("to_drop", 32'(core_irq), 32'd0);
        chk("to_noack", 32'(src_ack), 32'd0);
        read_arbsr("to_set", 1'b0);
        read_arbsr("to_cleared", 1'b0);

        // Timeout coinciding with a read leaves TO set.
        src_irq = 4'b1000;
        step();
        for (int k = 0; k < int'(TO_CYC) - 1; k++) step();
        iore = 1'b1;
        adr  = ADDR;
        #1;
        chk("to_rd_busy", 32'(dbus_out), 32'(arbsr_exp(1'b1)));
        step();
        iore    = 1'b0;
        adr     = 6'd0;
        src_irq = '0;
        to_m    = 1'b1;
        chk("to_rd_drop", 32'(core_irq), 32'd0);
        read_arbsr("to_rd_wins", 1'b0);

        // Randomized grants.
        for (int i = 0; i < 16; i++) begin
            logic [N-1:0] r;
            r = N'($urandom_range(1, (1 << N) - 1));
            do_grant(r, int'($urandom_range(0, TO_CYC - 1)), 1'($urandom_range(0, 1)), w, v);
        end
        src_irq = '0;
        step();
        read_arbsr("rand_arbsr", 1'b0);

        // Reset mid-GRANT aborts without an ack pulse.
        src_irq = 4'b1000;
        step();
        chk("rg_irq", 32'(core_irq), 32'd1);
        rstn     = 1'b0;
        core_ack = 1'b1;
        step();
        ptr_m  = 0;
        last_m = 3'd0;
        to_m   = 1'b0;
        chk("rg_irq_low", 32'(core_irq), 32'd0);
        chk("rg_ack", 32'(src_ack), 32'd0);
        chk("rg_vec", 32'(core_vec), 32'd0);
        iore = 1'b1;
        adr  = ADDR;
        #1;
        chk("rg_arbsr", 32'(dbus_out), 32'h00);
        core_ack = 1'b0;
        src_irq  = '0;
        iore     = 1'b0;
        adr      = 6'd0;
        rstn     = 1'b1;
        step();
        chk("rg_ack2", 32'(src_ack), 32'd0);
        do_grant(4'b1010, 2, 1'b1, w, v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
